// File: rtl/multi_sev_seg.sv
// multi_sev_seg
//   Multiplexed seven-segment driver with a shift-in digit store.
//   New hex digits shift in at digits[0]; the scan walks digit 0..N-1,
//   showing each for DIV_COUNT cycles followed by BLANK_CYCLES of dead
//   time with every digit off. A registered, inverted digit sum is also
//   provided.
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   digit_in     hex digit to shift in
//   digit_valid  one-cycle strobe: shift digit_in into digits[0]
//   clear        zero all stored digits (wins over digit_valid)
//   seg          active-low segments, seg[0]=a .. seg[6]=g
//   en           active-high digit enables, at most one bit set
//   sum_n        ~(sum of stored digits), one cycle behind storage
module multi_sev_seg #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV_COUNT    = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [3:0]                        digit_in,
  input  logic                              digit_valid,
  input  logic                              clear,
  output logic [6:0]                        seg,
  output logic [NUM_DIGITS-1:0]             en,
  output logic [3+$clog2(NUM_DIGITS):0]     sum_n
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int SUM_W   = 4 + IDX_W;
  // One counter serves both the show slot and the blank gap.
  localparam int CNT_MAX = (DIV_COUNT > BLANK_CYCLES) ? DIV_COUNT : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIV_COUNT - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {SHOW, BLANK} state_t;

  state_t                          state;
  logic [CNT_W-1:0]                cnt;
  logic [IDX_W-1:0]                idx;
  logic [IDX_W-1:0]                idx_nxt;
  logic [NUM_DIGITS-1:0][3:0]      digits;
  logic [SUM_W-1:0]                sum_c;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);

  // Scan sequencer; storage strobes never touch it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SHOW;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            cnt <= '0;
            if (BLANK_CYCLES > 0) state <= BLANK;
            else                  idx   <= idx_nxt;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt   <= '0;
            state <= SHOW;
            idx   <= idx_nxt;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= SHOW;
      endcase
    end
  end

  // Digit store: newest at [0], oldest falls off the top.
  always_ff @(posedge clk) begin
    if (reset || clear) digits <= '0;
    else if (digit_valid) digits <= {digits[NUM_DIGITS-2:0], digit_in};
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      sum_c = sum_c + {{(SUM_W-4){1'b0}}, digits[i]};
  end

  always_ff @(posedge clk) begin
    if (reset) sum_n <= '1;
    else       sum_n <= ~sum_c;
  end

  // Moore outputs: straight decode of scan state and stored digits.
  always_comb begin
    en  = '0;
    seg = 7'b1111111;
    if (state == SHOW) begin
      en  = NUM_DIGITS'(1) << idx;
      seg = hex7(digits[idx]);
    end
  end

endmodule

// File: tb/tb_multi_sev_seg.sv
module tb_multi_sev_seg;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] digit_in = '0;
  logic       digit_valid = 1'b0;
  logic       clear = 1'b0;

  logic [6:0] seg_a, seg_b, seg_c;
  logic [1:0] en_a, en_c;
  logic [3:0] en_b;
  logic [4:0] sum_a, sum_c;
  logic [5:0] sum_b;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: cycles since reset, stored digits, expected sums
  int         t = 0;
  int         dig [4];
  logic [4:0] xs_a = '1, xs_c = '1;
  logic [5:0] xs_b = '1;

  always #5 clk = ~clk;

  multi_sev_seg #(.NUM_DIGITS(2), .DIV_COUNT(4), .BLANK_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .digit_in(digit_in), .digit_valid(digit_valid),
    .clear(clear), .seg(seg_a), .en(en_a), .sum_n(sum_a));
  multi_sev_seg #(.NUM_DIGITS(4), .DIV_COUNT(4), .BLANK_CYCLES(2)) dut_b (
    .clk(clk), .reset(reset), .digit_in(digit_in), .digit_valid(digit_valid),
    .clear(clear), .seg(seg_b), .en(en_b), .sum_n(sum_b));
  multi_sev_seg #(.NUM_DIGITS(2), .DIV_COUNT(4), .BLANK_CYCLES(0)) dut_c (
    .clk(clk), .reset(reset), .digit_in(digit_in), .digit_valid(digit_valid),
    .clear(clear), .seg(seg_c), .en(en_c), .sum_n(sum_c));

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: glyph = 7'b1000000;  1: glyph = 7'b1111001;
      2: glyph = 7'b0100100;  3: glyph = 7'b0110000;
      4: glyph = 7'b0011001;  5: glyph = 7'b0010010;
      6: glyph = 7'b0000010;  7: glyph = 7'b1111000;
      8: glyph = 7'b0000000;  9: glyph = 7'b0010000;
      10: glyph = 7'b0001000; 11: glyph = 7'b0000011;
      12: glyph = 7'b1000110; 13: glyph = 7'b0100001;
      14: glyph = 7'b0000110; default: glyph = 7'b0001110;
    endcase
  endfunction

  // Expected outputs from the time position inside the scan period.
  function automatic void exp_scan(input int nd, input int blk,
                                   output logic [7:0] e_en, output logic [6:0] e_seg);
    int sl, p, ix, off;
    sl  = 4 + blk;
    p   = t % (nd * sl);
    ix  = p / sl;
    off = p % sl;
    if (off < 4) begin
      e_en  = 8'(1 << ix);
      e_seg = glyph(dig[ix]);
    end else begin
      e_en  = 8'h00;
      e_seg = 7'h7f;
    end
  endfunction

  // One clock edge; the model absorbs the inputs present at that edge.
  task automatic cyc();
    int s2, s4;
    @(posedge clk);
    if (reset) begin
      t = 0;
      for (int i = 0; i < 4; i++) dig[i] = 0;
      xs_a = '1; xs_b = '1; xs_c = '1;
    end else begin
      s2 = dig[0] + dig[1];
      s4 = s2 + dig[2] + dig[3];
      xs_a = ~5'(s2); xs_c = ~5'(s2); xs_b = ~6'(s4);
      t++;
      if (clear) begin
        for (int i = 0; i < 4; i++) dig[i] = 0;
      end else if (digit_valid) begin
        for (int i = 3; i > 0; i--) dig[i] = dig[i-1];
        dig[0] = int'(digit_in);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; digit_valid = 1'b0; clear = 1'b0;
    cyc(); cyc();
    n_cmp++; if (en_a !== 2'b01) begin n_bad++; $display("FAIL reset_en_a got %b want 01", en_a); end
    n_cmp++; if (seg_a !== 7'b1000000) begin n_bad++; $display("FAIL reset_seg_a got %b want 1000000", seg_a); end
    n_cmp++; if (sum_a !== 5'b11111) begin n_bad++; $display("FAIL reset_sum_a got %b want 11111", sum_a); end
    n_cmp++; if (en_b !== 4'b0001) begin n_bad++; $display("FAIL reset_en_b got %b want 0001", en_b); end
    n_cmp++; if (sum_b !== 6'b111111) begin n_bad++; $display("FAIL reset_sum_b got %b want 111111", sum_b); end
    reset = 1'b0;
  endtask

  task automatic test_scan();
    logic [1:0] pat [12];
    logic [1:0] ec;
    logic [6:0] es;
    logic [7:0] eb;
    logic [6:0] sb;
    pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00,
            2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
    for (int i = 0; i < 24; i++) begin
      es = (pat[t % 12] != 2'b00) ? 7'b1000000 : 7'b1111111;
      ec = ((t % 8) < 4) ? 2'b01 : 2'b10;
      exp_scan(4, 2, eb, sb);
      n_cmp++; if (en_a !== pat[t % 12]) begin n_bad++; $display("FAIL scan_en_a t=%0d got %b want %b", t, en_a, pat[t % 12]); end
      n_cmp++; if (seg_a !== es) begin n_bad++; $display("FAIL scan_seg_a t=%0d got %b want %b", t, seg_a, es); end
      n_cmp++; if (en_c !== ec) begin n_bad++; $display("FAIL scan_en_c t=%0d got %b want %b", t, en_c, ec); end
      n_cmp++; if ({4'b0, en_b} !== eb) begin n_bad++; $display("FAIL scan_en_b t=%0d got %b want %b", t, en_b, eb[3:0]); end
      cyc();
    end
  endtask

  task automatic test_shift();
    logic [7:0] ea;
    logic [6:0] sa, want;
    clear = 1'b1; cyc(); clear = 1'b0;
    digit_in = 4'h3; digit_valid = 1'b1; cyc();
    digit_in = 4'hA; cyc();
    digit_valid = 1'b0; cyc();
    n_cmp++; if (sum_a !== 5'b10010) begin n_bad++; $display("FAIL shift_sum_a got %b want 10010", sum_a); end
    for (int i = 0; i < 12; i++) begin
      exp_scan(2, 2, ea, sa);
      want = (ea == 8'd1) ? 7'b0001000 : (ea == 8'd2) ? 7'b0110000 : 7'b1111111;
      n_cmp++; if ({6'b0, en_a} !== ea) begin n_bad++; $display("FAIL shift_en_a t=%0d got %b want %b", t, en_a, ea[1:0]); end
      n_cmp++; if (seg_a !== want) begin n_bad++; $display("FAIL shift_seg_a t=%0d got %b want %b", t, seg_a, want); end
      cyc();
    end
  endtask

  task automatic test_overflow();
    clear = 1'b1; cyc(); clear = 1'b0;
    digit_in = 4'hF; digit_valid = 1'b1;
    repeat (4) cyc();
    digit_valid = 1'b0; cyc();
    n_cmp++; if (sum_b !== 6'b000011) begin n_bad++; $display("FAIL ovf_sum_b got %b want 000011", sum_b); end
    n_cmp++; if (sum_a !== 5'b00001) begin n_bad++; $display("FAIL ovf_sum_a got %b want 00001", sum_a); end
    digit_in = 4'h0; digit_valid = 1'b1; cyc();
    digit_valid = 1'b0; cyc();
    n_cmp++; if (sum_b !== 6'b010010) begin n_bad++; $display("FAIL ovf5_sum_b got %b want 010010", sum_b); end
  endtask

  task automatic test_priority();
    digit_in = 4'h7; digit_valid = 1'b1; clear = 1'b1; cyc();
    digit_valid = 1'b0; clear = 1'b0; cyc();
    n_cmp++; if (sum_b !== 6'b111111) begin n_bad++; $display("FAIL prio_sum_b got %b want 111111", sum_b); end
    n_cmp++; if (sum_a !== 5'b11111) begin n_bad++; $display("FAIL prio_sum_a got %b want 11111", sum_a); end
    // move into a blank gap of dut_a, then reset there
    for (int i = 0; i < 12 && (t % 6) < 4; i++) cyc();
    n_cmp++; if (en_a !== 2'b00) begin n_bad++; $display("FAIL prio_blank_en_a got %b want 00", en_a); end
    reset = 1'b1; cyc(); reset = 1'b0;
    n_cmp++; if (en_a !== 2'b01) begin n_bad++; $display("FAIL prio_rst_en_a got %b want 01", en_a); end
    cyc();
    n_cmp++; if (en_a !== 2'b01) begin n_bad++; $display("FAIL prio_post_en_a got %b want 01", en_a); end
  endtask

  task automatic test_noblank();
    int run;
    logic [1:0] prev;
    run = 0; prev = en_c;
    for (int i = 0; i < 20; i++) begin
      digit_in = 4'(i); digit_valid = (i == 6);
      n_cmp++; if (en_c === 2'b00) begin n_bad++; $display("FAIL noblank_en_c t=%0d got 00 want nonzero", t); end
      cyc();
      if (en_c === prev) run++;
      else begin
        // the first run is partial; every later one must be a full slot
        if (i > 4) begin
          n_cmp++; if (run !== 3) begin n_bad++; $display("FAIL noblank_slot got %0d want 4", run + 1); end
        end
        run = 0;
      end
      prev = en_c;
    end
    digit_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] ea, eb, ec;
    logic [6:0] sa, sb, sc;
    for (int i = 0; i < 400; i++) begin
      digit_in    = 4'($urandom);
      digit_valid = ($urandom_range(0, 2) == 0);
      clear       = ($urandom_range(0, 24) == 0);
      reset       = ($urandom_range(0, 59) == 0);
      cyc();
      exp_scan(2, 2, ea, sa);
      exp_scan(4, 2, eb, sb);
      exp_scan(2, 0, ec, sc);
      n_cmp++; if ({6'b0, en_a} !== ea || seg_a !== sa) begin n_bad++; $display("FAIL rand_a t=%0d got %b/%b want %b/%b", t, en_a, seg_a, ea[1:0], sa); end
      n_cmp++; if ({4'b0, en_b} !== eb || seg_b !== sb) begin n_bad++; $display("FAIL rand_b t=%0d got %b/%b want %b/%b", t, en_b, seg_b, eb[3:0], sb); end
      n_cmp++; if ({6'b0, en_c} !== ec || seg_c !== sc) begin n_bad++; $display("FAIL rand_c t=%0d got %b/%b want %b/%b", t, en_c, seg_c, ec[1:0], sc); end
      n_cmp++; if (sum_a !== xs_a || sum_b !== xs_b || sum_c !== xs_c) begin
        n_bad++; $display("FAIL rand_sum t=%0d got %b/%b/%b want %b/%b/%b", t, sum_a, sum_b, sum_c, xs_a, xs_b, xs_c);
      end
    end
    digit_valid = 1'b0; clear = 1'b0; reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) dig[i] = 0;
    test_reset();
    test_scan();
    test_shift();
    test_overflow();
    test_priority();
    test_noblank();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_sev_seg.md
MULTI_SEV_SEG -- requirements
Module: multi_sev_seg

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning number of multiplexed seven-segment digits (legal range 2..8).
REQ-002 SHALL have parameter DIV_COUNT, default 100000, meaning clk cycles each digit is driven per scan slot (legal range >= 1).
REQ-003 SHALL have parameter BLANK_CYCLES, default 1000, meaning dead-time clk cycles with all digits off between slots (legal range >= 0).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port digit_in  input  4  hex value to store.
REQ-007 SHALL have port digit_valid  input  1  one-cycle strobe that shifts digit_in into storage.
REQ-008 SHALL have port clear  input  1  synchronous clear of all stored digits.
REQ-009 SHALL have port seg  output  7  active-low segments, seg[0]=a through seg[6]=g.
REQ-010 SHALL have port en  output  NUM_DIGITS  active-high digit enables, at most one bit high.
REQ-011 SHALL have port sum_n  output  4+clog2(NUM_DIGITS)  bitwise inverse of the unsigned sum of all stored digits.

Function
REQ-012 SHALL hold storage digits[0..NUM_DIGITS-1] of 4 bits each; digits[0] is the newest digit.
REQ-013 On digit_valid, SHALL set digits[k] <= digits[k-1] for k>=1 and digits[0] <= digit_in; the oldest digit is discarded.
REQ-014 On clear, SHALL zero all digits; clear has priority over a simultaneous digit_valid.
REQ-015 SHALL implement FSM states SHOW and BLANK, with a slot counter cnt and a digit index idx.
REQ-016 In SHOW, SHALL drive en = one-hot(idx) and seg = decode(digits[idx]); leaving SHOW when cnt reaches DIV_COUNT-1 resets cnt to 0.
REQ-017 On leaving SHOW, SHALL enter BLANK if BLANK_CYCLES>0; otherwise SHALL advance idx and stay in SHOW.
REQ-018 In BLANK, SHALL drive en=0 and seg=7'b1111111.
REQ-019 SHALL leave BLANK after BLANK_CYCLES cycles, advance idx, and return to SHOW.
REQ-020 idx SHALL advance 0,1,...,NUM_DIGITS-1 and wrap to 0; scan period SHALL be NUM_DIGITS*(DIV_COUNT+BLANK_CYCLES) cycles.
REQ-021 seg and en SHALL be a Moore decode of registered state and storage; a digit update is visible on seg the cycle after the strobe edge.
REQ-022 decode SHALL produce standard hex glyphs, e.g. 0->1000000, 1->1111001, 8->0000000, A->0001000, F->0001110.
REQ-023 sum_n SHALL be registered and reflect storage with one cycle of latency; the sum SHALL never overflow its width.
REQ-024 digit_valid and clear SHALL NOT disturb the scan state, cnt, or idx.

Reset
REQ-025 While reset is high at a clock edge: state=SHOW, idx=0, cnt=0, all digits=0, sum_n=all ones.
REQ-026 After reset, seg=1000000 and en=one-hot(0); reset asserted mid-slot or mid-BLANK SHALL restart the scan at digit 0 on the next edge.
REQ-027 Storage SHALL ignore digit_valid and clear in any cycle where reset is high.

Verification
Use NUM_DIGITS=2, DIV_COUNT=4, BLANK_CYCLES=2 unless stated.
REQ-028 Scan test: after reset, with no strobes -> en sequence 01 x4, 00 x2, 10 x4, 00 x2, repeating; seg=1000000 whenever en!=0 and 1111111 whenever en=0.
REQ-029 Shift test: strobe 0x3, then 0xA -> digits[0]=A, digits[1]=3; slot 0 seg=0001000, slot 1 seg=0110000; sum_n=~5'd13=10010.
REQ-030 Overflow/width test: NUM_DIGITS=4, strobe F four times -> sum_n=~6'd60=000011; a fifth strobe of 0 -> sum_n=~6'd45=010010.
REQ-031 Priority test: clear and digit_valid (0x7) in the same cycle -> all digits 0, sum_n all ones; a reset asserted mid-BLANK -> en=01 on the cycle after reset deasserts.
REQ-032 No-blank test: BLANK_CYCLES=0 -> en alternates 01 x4, 10 x4 with no 00 cycles; a strobe during a slot leaves the slot length unchanged at 4 cycles.
